// File: rtl/vga_pkg.sv
// vga_pkg: shared colour types and the power-on palette for the VGA pixel stage.
package vga_pkg;

    typedef logic [14:0] rgb555_t;

    localparam rgb555_t COLOR_BLACK = 15'h0000;
    localparam rgb555_t COLOR_WHITE = 15'h7FFF;

    // Power-on palette contents, {R5,G5,B5}.
    localparam rgb555_t DEFAULT_PALETTE [16] = '{
        15'h0000, 15'h7FFF, 15'h4400, 15'h2B3D,
        15'h4C19, 15'h1A48, 15'h0C14, 15'h77AE,
        15'h4D05, 15'h2880, 15'h6E31, 15'h18C6,
        15'h35AD, 15'h4B8D, 15'h2D7F, 15'h5AD6
    };

endpackage

// File: rtl/vga_palette.sv
// vga_palette: 2**IDX_W x RGB555 register file, one sync write port, one registered read port.
module vga_palette
    import vga_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [14:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [14:0]      rdata
);

    localparam int unsigned Depth = 2 ** IDX_W;

    rgb555_t mem_q [Depth];

    // Storage: reset loads the default table (repeated for deeper palettes).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= DEFAULT_PALETTE[4'(i)];
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write is not forwarded, so the old value is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= COLOR_BLACK;
        end else begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: scales a GRID_W x GRID_H indexed framebuffer onto the VGA raster,
// three clocks from hpos to rgb, with hsync/vsync delayed to match.
// Build macro GRID_LINES_EN: adds a 1-pixel white overlay on the first row/column of each cell.
module vga_grid_renderer
    import vga_pkg::*;
#(
    parameter int unsigned  GRID_W   = 32,
    parameter int unsigned  GRID_H   = 32,
    parameter int unsigned  CELL     = 15,
    parameter int unsigned  X0       = 80,
    parameter int unsigned  Y0       = 0,
    parameter int unsigned  IDX_W    = 4,
    parameter rgb555_t      BG_COLOR = 15'h0,
    localparam int unsigned AW       = $clog2(GRID_W * GRID_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic             display_on,
    input  logic             hmaxxed,
    input  logic             vmaxxed,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [AW-1:0]    fb_addr,
    input  logic [IDX_W-1:0] fb_data,
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_addr,
    input  logic [14:0]      pal_data,
    output logic             hsync,
    output logic             vsync,
    output logic [14:0]      rgb
);

    localparam int unsigned    SW        = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int unsigned    CXW       = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned    CYW       = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam logic [10:0]    XBeg      = 11'(X0);
    localparam logic [10:0]    XLen      = 11'(GRID_W * CELL);
    localparam logic [10:0]    YBeg      = 11'(Y0);
    localparam logic [10:0]    YLen      = 11'(GRID_H * CELL);
    localparam logic [SW-1:0]  SubLast   = SW'(CELL - 1);
    localparam logic [CXW-1:0] CellXLast = CXW'(GRID_W - 1);
    localparam logic [CYW-1:0] CellYLast = CYW'(GRID_H - 1);

    logic [10:0]    hoff, voff;
    logic           in_x, in_y, at_x0;
    logic [SW-1:0]  subx_q, subx_d, subx_cur, suby_q, suby_d;
    logic [CXW-1:0] cellx_q, cellx_d, cellx_cur;
    logic [CYW-1:0] celly_q, celly_d;
    logic [AW-1:0]  fb_addr_d, fb_addr_q;
    logic           frame_ok_q;
    logic [2:0]     de_q, inx_q, iny_q, hs_q, vs_q;
    logic [14:0]    pal_rdata;

    // Window decode; offsets wrap below the origin so one compare covers both bounds.
    always_comb begin
        hoff      = {1'b0, hpos} - XBeg;
        voff      = {1'b0, vpos} - YBeg;
        in_x      = hoff < XLen;
        in_y      = voff < YLen;
        at_x0     = hoff == 11'd0;
        subx_cur  = at_x0 ? '0 : subx_q;
        cellx_cur = at_x0 ? '0 : cellx_q;
        fb_addr_d = AW'(celly_q) * AW'(GRID_W) + AW'(cellx_cur);
    end

    // Horizontal cell counters: step per pixel inside the window, cellx saturates.
    always_comb begin
        subx_d  = subx_cur;
        cellx_d = cellx_cur;
        if (in_x) begin
            if (subx_cur == SubLast) begin
                subx_d = '0;
                if (cellx_cur != CellXLast) cellx_d = cellx_cur + CXW'(1);
            end else begin
                subx_d = subx_cur + SW'(1);
            end
        end
    end

    // Vertical cell counters: step per line end, end-of-frame clear wins.
    always_comb begin
        suby_d  = suby_q;
        celly_d = celly_q;
        if (hmaxxed && vmaxxed) begin
            suby_d  = '0;
            celly_d = '0;
        end else if (hmaxxed && in_y) begin
            if (suby_q == SubLast) begin
                suby_d = '0;
                if (celly_q != CellYLast) celly_d = celly_q + CYW'(1);
            end else begin
                suby_d = suby_q + SW'(1);
            end
        end
    end

    // Counter state; frame_ok keeps output dark until a full frame boundary after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            subx_q     <= '0;
            cellx_q    <= '0;
            suby_q     <= '0;
            celly_q    <= '0;
            frame_ok_q <= 1'b0;
        end else begin
            subx_q  <= subx_d;
            cellx_q <= cellx_d;
            suby_q  <= suby_d;
            celly_q <= celly_d;
            if (hmaxxed && vmaxxed) frame_ok_q <= 1'b1;
        end
    end

    // Delay line: [0]=S0 (with fb_addr), [1]=S1 (fb_data back), [2]=S2 (palette out).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_addr_q <= '0;
            de_q      <= '0;
            inx_q     <= '0;
            iny_q     <= '0;
            hs_q      <= '0;
            vs_q      <= '0;
        end else begin
            fb_addr_q <= fb_addr_d;
            de_q      <= {de_q[1:0], display_on & frame_ok_q};
            inx_q     <= {inx_q[1:0], in_x};
            iny_q     <= {iny_q[1:0], in_y};
            hs_q      <= {hs_q[1:0], hsync_in};
            vs_q      <= {vs_q[1:0], vsync_in};
        end
    end

`ifdef GRID_LINES_EN
    logic [2:0] line_q;

    // Overlay flag travels with the pixel so latency is unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
        end else begin
            line_q <= {line_q[1:0], (subx_cur == '0) || (suby_q == '0)};
        end
    end
`endif

    vga_palette #(
        .IDX_W(IDX_W)
    ) u_palette (
        .clk  (clk),
        .reset(reset),
        .we   (pal_we),
        .waddr(pal_addr),
        .wdata(pal_data),
        .raddr(fb_data),
        .rdata(pal_rdata)
    );

    assign fb_addr = fb_addr_q;
    assign hsync   = hs_q[2];
    assign vsync   = vs_q[2];

    // Output colour select from the S2 flags and the registered palette word.
    always_comb begin
        rgb = COLOR_BLACK;
        if (de_q[2]) begin
            if (inx_q[2] && iny_q[2]) begin
                rgb = pal_rdata;
`ifdef GRID_LINES_EN
                if (line_q[2]) rgb = COLOR_WHITE;
`endif
            end else begin
                rgb = BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: scoreboard bench; expected pixels are queued at drive time and
// compared three clocks later against an arithmetic model of the grid.
module tb_vga_grid_renderer;

    localparam logic [14:0] BG = 15'h2A55;
    localparam logic [14:0] DEF_PAL [16] = '{
        15'h0000, 15'h7FFF, 15'h4400, 15'h2B3D,
        15'h4C19, 15'h1A48, 15'h0C14, 15'h77AE,
        15'h4D05, 15'h2880, 15'h6E31, 15'h18C6,
        15'h35AD, 15'h4B8D, 15'h2D7F, 15'h5AD6
    };

    typedef struct {
        bit          care;
        int          h;
        int          v;
        logic [14:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos;
    logic        display_on, hmaxxed, vmaxxed, hsync_in, vsync_in;
    logic [9:0]  fb_addr;
    logic [3:0]  fb_data;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [14:0] pal_data;
    logic        hsync, vsync;
    logic [14:0] rgb;

    logic [3:0]  fb_m [1024];
    logic [14:0] pal_m [16];
    bit          armed;
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    vga_grid_renderer #(
        .BG_COLOR(BG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hpos      (hpos),
        .vpos      (vpos),
        .display_on(display_on),
        .hmaxxed   (hmaxxed),
        .vmaxxed   (vmaxxed),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb       (rgb)
    );

    always #5 clk = ~clk;

    // External framebuffer RAM: data valid one clock after the address.
    always @(posedge clk) fb_data <= fb_m[fb_addr];

    function automatic logic [14:0] model(input int h, input int v, input bit de);
        int cx, cy;
        if (!de || !armed) return 15'h0000;
        if (h < 80 || h >= 560 || v >= 480) return BG;
        cx = (h - 80) / 15;
        cy = v / 15;
`ifdef GRID_LINES_EN
        if ((h - 80) % 15 == 0 || v % 15 == 0) return 15'h7FFF;
`endif
        return pal_m[fb_m[cy * 32 + cx]];
    endfunction

    task automatic drive(input int h, input int v, input bit de, input bit hm, input bit vm,
                         input bit hs, input bit vs, input bit care);
        exp_t e;
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = de;
        hmaxxed    = hm;
        vmaxxed    = vm;
        hsync_in   = hs;
        vsync_in   = vs;
        e.care = care;
        e.h    = h;
        e.v    = v;
        e.rgb  = model(h, v, de);
        e.hs   = hs;
        e.vs   = vs;
        exp_q.push_back(e);
        if (hm && vm) armed = 1'b1;
    endtask

    // Frame boundary then one line-end per line, leaving the raster at the start of line v.
    task automatic goto_line(input int v);
        drive(799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int l = 0; l < v; l++) begin
            drive(799, l, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (rgb !== 15'h0000 || hsync !== 1'b0 || vsync !== 1'b0 || fb_addr !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_state: rgb=%h hsync=%b vsync=%b fb_addr=%0d, expected all zero",
                     rgb, hsync, vsync, fb_addr);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        armed = 1'b0;
    endtask

    task automatic test_reset_midline();
        exp_t e;
        goto_line(0);
        for (int h = 78; h <= 305; h++) begin
            drive(h, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            @(posedge clk); #1;
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                if (e.care) begin
                    n_checks++;
                    if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                        n_errors++;
                        $display("FAIL pre_reset h=%0d: rgb=%h hs=%b vs=%b, expected %h %b %b",
                                 e.h, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                    end
                end
            end
        end
        exp_q.delete();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (rgb !== 15'h0000 || hsync !== 1'b0 || vsync !== 1'b0 || fb_addr !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_midline: rgb=%h hsync=%b vsync=%b fb_addr=%0d, expected zeros",
                     rgb, hsync, vsync, fb_addr);
        end
        armed = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        // No frame boundary yet: the line must stay dark.
        for (int h = 78; h <= 113; h++) begin
            if (h <= 110) drive(h, 0, 1'b1, 1'b0, 1'b0, 1'($urandom()), 1'($urandom()), 1'b1);
            else drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                if (e.care) begin
                    n_checks++;
                    if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                        n_errors++;
                        $display("FAIL post_reset h=%0d: rgb=%h hs=%b vs=%b, expected %h %b %b",
                                 e.h, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                    end
                end
            end
        end
    endtask

    task automatic test_pixels();
        exp_t e;
        int   v, hlast;
        for (int s = 0; s < 2; s++) begin
            v     = (s == 0) ? 0 : 20;
            hlast = (s == 0) ? 565 : 200;
            goto_line(v);
            for (int h = 76; h <= hlast + 3; h++) begin
                if (h <= hlast)
                    drive(h, v, 1'b1, 1'b0, 1'b0, 1'($urandom()), 1'($urandom()), 1'b1);
                else
                    drive(0, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                @(posedge clk); #1;
                if (exp_q.size() == 3) begin
                    e = exp_q.pop_front();
                    if (e.care) begin
                        n_checks++;
                        if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                            n_errors++;
                            $display("FAIL pixel h=%0d v=%0d: rgb=%h hs=%b vs=%b, expected %h %b %b",
                                     e.h, e.v, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_background();
        exp_t e;
        bit   de;
        goto_line(2);
        for (int h = 70; h <= 573; h++) begin
            de = !(h == 79 || h == 560 || (h >= 300 && h < 305));
            if (h <= 570) drive(h, 2, de, 1'b0, 1'b0, 1'($urandom()), 1'($urandom()), 1'b1);
            else drive(0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                if (e.care) begin
                    n_checks++;
                    if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                        n_errors++;
                        $display("FAIL background h=%0d: rgb=%h hs=%b vs=%b, expected %h %b %b",
                                 e.h, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                    end
                end
            end
        end
    endtask

    task automatic test_vertical();
        exp_t e;
        int   th [6] = '{80, 81, 799, 80, 799, 80};
        int   tv [6] = '{14, 14, 14, 15, 15, 0};
        bit   td [6] = '{1, 1, 0, 1, 0, 1};
        bit   thm [6] = '{0, 0, 1, 0, 1, 0};
        bit   tvm [6] = '{0, 0, 0, 0, 1, 0};
        bit   tck [6] = '{1, 0, 0, 1, 0, 1};
        int   exp_addr;
        goto_line(14);
        for (int i = 0; i < 9; i++) begin
            if (i < 6) drive(th[i], tv[i], td[i], thm[i], tvm[i], 1'b0, 1'b1, 1'b1);
            else drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (i < 6 && tck[i]) begin
                exp_addr = (tv[i] / 15) * 32 + (th[i] - 80) / 15;
                n_checks++;
                if (fb_addr !== 10'(exp_addr)) begin
                    n_errors++;
                    $display("FAIL fb_addr step=%0d: got %0d, expected %0d", i, fb_addr, exp_addr);
                end
            end
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                if (e.care) begin
                    n_checks++;
                    if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                        n_errors++;
                        $display("FAIL vertical h=%0d v=%0d: rgb=%h hs=%b vs=%b, expected %h %b %b",
                                 e.h, e.v, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                    end
                end
            end
        end
    endtask

    task automatic test_palette();
        exp_t e;
        goto_line(1);
        for (int h = 78; h <= 143; h++) begin
            pal_we = 1'b0;
            if (h == 131) begin
                // Written now: pixel 129 reads at this edge (old), pixel 130 after it (new).
                pal_we   = 1'b1;
                pal_addr = 4'd3;
                pal_data = 15'h7C00;
                pal_m[3] = 15'h7C00;
                e = exp_q.pop_back();
                e.rgb = model(e.h, e.v, 1'b1);
                exp_q.push_back(e);
            end
            if (h <= 140) drive(h, 1, 1'b1, 1'b0, 1'b0, 1'($urandom()), 1'($urandom()), 1'b1);
            else drive(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                if (e.care) begin
                    n_checks++;
                    if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                        n_errors++;
                        $display("FAIL palette h=%0d: rgb=%h hs=%b vs=%b, expected %h %b %b",
                                 e.h, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                    end
                end
            end
        end
        pal_we = 1'b0;
    endtask

    task automatic test_overlay();
        exp_t e;
        goto_line(1);
        for (int h = 76; h <= 133; h++) begin
            if (h <= 130) drive(h, 1, 1'b1, 1'b0, 1'b0, 1'($urandom()), 1'($urandom()), 1'b1);
            else drive(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                if (e.care) begin
                    n_checks++;
                    if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                        n_errors++;
                        $display("FAIL overlay h=%0d: rgb=%h hs=%b vs=%b, expected %h %b %b",
                                 e.h, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        hpos       = '0;
        vpos       = '0;
        display_on = 1'b0;
        hmaxxed    = 1'b0;
        vmaxxed    = 1'b0;
        hsync_in   = 1'b0;
        vsync_in   = 1'b0;
        pal_we     = 1'b0;
        pal_addr   = '0;
        pal_data   = '0;
        armed      = 1'b0;
        for (int i = 0; i < 1024; i++) fb_m[i] = 4'(i % 16);
        for (int i = 0; i < 16; i++) pal_m[i] = DEF_PAL[i];

        test_reset();
        test_reset_midline();
        test_pixels();
        test_background();
        test_vertical();
        test_palette();
        test_overlay();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
